servant_uart: RTL and testbench

SERVANT_UART -- requirements
Module: servant_uart

---
 rtl/servant_uart_pkg.sv | 46 ++++
 rtl/servant_uart_fifo.sv | 68 ++++++
 rtl/servant_uart.sv | 250 +++++++++++++++++++++++++
 tb/tb_servant_uart.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/servant_uart_pkg.sv
// Shared definitions for the servant UART transmitter: FSM encoding,
// register map and STATUS word layout.
package servant_uart_pkg;

  // Transmit FSM states; busy is any state other than ST_IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;

  // Register select on i_wb_adr.
  localparam logic ADDR_DATA = 1'b0;
  localparam logic ADDR_CTRL = 1'b1;

  // STATUS word bit positions.
  localparam int STAT_FULL    = 0;
  localparam int STAT_EMPTY   = 1;
  localparam int STAT_BUSY    = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_IRQ_EN  = 4;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 8;

  // Assemble the STATUS word; every bit not named above reads as zero.
  function automatic logic [31:0] pack_status(
    input logic                  full,
    input logic                  empty,
    input logic                  busy,
    input logic                  ovf,
    input logic                  irq_en,
    input logic [STAT_CNT_W-1:0] count
  );
    logic [31:0] v;
    v                                       = 32'd0;
    v[STAT_FULL]                            = full;
    v[STAT_EMPTY]                           = empty;
    v[STAT_BUSY]                            = busy;
    v[STAT_OVF]                             = ovf;
    v[STAT_IRQ_EN]                          = irq_en;
    v[STAT_CNT_LSB +: STAT_CNT_W]           = count;
    return v;
  endfunction

endpackage

// File: rtl/servant_uart_fifo.sv
// Transmit FIFO with first-word-fall-through read data. A push is accepted
// only when the FIFO was not full before the edge, regardless of any pop.
module servant_uart_fifo
  import servant_uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("servant_uart_fifo: DEPTH must be a power of two in 2..256");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == {(AW+1){1'b0}});
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage array; contents are don't-care until written, so it has no reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers and occupancy; a simultaneous push and pop keeps the count.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/servant_uart.sv
// Wishbone-attached UART transmitter: DATA register feeds a transmit FIFO,
// CTRL/STATUS gives interrupt enable and status. The serial output is
// registered from the current FSM state, so the line lags the state by
// one cycle while every bit still lasts exactly CLK_DIV cycles.
module servant_uart
  import servant_uart_pkg::*;
#(
  parameter int CLK_DIV    = 139,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_uart_tx,
  output logic        o_irq
);

  if ((CLK_DIV < 2) || (CLK_DIV > 65535)) begin : g_bad_clk_div
    $error("servant_uart: CLK_DIV must be in 2..65535");
  end
  if ((FIFO_DEPTH < 2) || (FIFO_DEPTH > 256) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("servant_uart: FIFO_DEPTH must be a power of two in 2..256");
  end
  if ((DATA_W < 5) || (DATA_W > 8)) begin : g_bad_data_w
    $error("servant_uart: DATA_W must be in 5..8");
  end
  if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
    $error("servant_uart: STOP_BITS must be 1 or 2");
  end

  localparam int                BAUD_W      = $clog2(CLK_DIV);
  localparam int                CNT_W       = $clog2(FIFO_DEPTH) + 1;
  localparam int                BIT_W       = $clog2(DATA_W);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT    = BIT_W'(DATA_W - 1);
  localparam logic              STOP_LAST   = (STOP_BITS == 2) ? 1'b1 : 1'b0;

  // Bus side
  logic              r_ack;
  logic [31:0]       r_rdt;
  logic              r_irq_en;
  logic              r_ovf;
  logic              r_irq;
  logic              w_access;
  logic              w_wr_data;
  logic              w_wr_ctrl;
  logic              w_rd_stat;
  logic              w_ovf_event;
  logic [31:0]       w_status;
  logic              w_unused_dat;

  // FIFO side
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [DATA_W-1:0] w_fifo_dout;
  logic              w_pop;

  // Transmitter
  tx_state_t         r_state;
  tx_state_t         w_state_nxt;
  logic [BAUD_W-1:0] r_baud;
  logic [BAUD_W-1:0] w_baud_nxt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [BIT_W-1:0]  r_bit;
  logic [BIT_W-1:0]  w_bit_nxt;
  logic              r_stop;
  logic              w_stop_nxt;
  logic              w_baud_done;
  logic              w_busy;
  logic              w_tx_bit;
  logic              r_tx;

  // One access per stb; it commits on the edge that raises ack.
  assign w_access     = i_wb_stb & ~r_ack;
  assign w_wr_data    = w_access &  i_wb_we & (i_wb_adr == ADDR_DATA);
  assign w_wr_ctrl    = w_access &  i_wb_we & (i_wb_adr == ADDR_CTRL);
  assign w_rd_stat    = w_access & ~i_wb_we & (i_wb_adr == ADDR_CTRL);
  assign w_ovf_event  = w_wr_data & w_full;
  assign w_busy       = (r_state != ST_IDLE);
  assign w_baud_done  = (r_baud == {BAUD_W{1'b0}});
  assign w_status     = pack_status(w_full, w_empty, w_busy, r_ovf, r_irq_en,
                                    STAT_CNT_W'(w_count));
  assign w_unused_dat = ^i_wb_dat[31:DATA_W];

  assign o_wb_ack  = r_ack;
  assign o_wb_rdt  = r_rdt;
  assign o_uart_tx = r_tx;
  assign o_irq     = r_irq;

  servant_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_wr_data),
    .i_pop   (w_pop),
    .i_data  (i_wb_dat[DATA_W-1:0]),
    .o_data  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  // Bus acknowledge, read data, control and sticky overflow registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ack    <= 1'b0;
      r_rdt    <= 32'd0;
      r_irq_en <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_ack <= w_access;
      r_rdt <= w_rd_stat ? w_status : 32'd0;
      if (w_wr_ctrl) begin
        r_irq_en <= i_wb_dat[0];
      end
      // A dropped push in the same cycle as a STATUS read keeps the flag set.
      if (w_ovf_event) begin
        r_ovf <= 1'b1;
      end else if (w_rd_stat) begin
        r_ovf <= 1'b0;
      end
    end
  end

  // Transmit-complete interrupt, registered from the pre-edge state.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_irq_en & w_empty & ~w_busy;
    end
  end

  // FSM state and transmit datapath registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_baud  <= {BAUD_W{1'b0}};
      r_shift <= {DATA_W{1'b0}};
      r_bit   <= {BIT_W{1'b0}};
      r_stop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_baud  <= w_baud_nxt;
      r_shift <= w_shift_nxt;
      r_bit   <= w_bit_nxt;
      r_stop  <= w_stop_nxt;
    end
  end

  // Next-state logic: each bit starts by reloading the baud counter, which
  // counts down to zero; leaving STOP pops straight into START when possible.
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit;
    w_stop_nxt  = r_stop;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_dout;
          w_baud_nxt  = BAUD_RELOAD;
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_baud_done) begin
          w_baud_nxt  = BAUD_RELOAD;
          w_bit_nxt   = {BIT_W{1'b0}};
          w_state_nxt = ST_DATA;
        end else begin
          w_baud_nxt  = r_baud - BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (w_baud_done) begin
          w_baud_nxt  = BAUD_RELOAD;
          w_shift_nxt = {1'b0, r_shift[DATA_W-1:1]};
          if (r_bit == LAST_BIT) begin
            w_stop_nxt  = 1'b0;
            w_state_nxt = ST_STOP;
          end else begin
            w_bit_nxt   = r_bit + BIT_W'(1);
          end
        end else begin
          w_baud_nxt  = r_baud - BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (w_baud_done) begin
          w_baud_nxt = BAUD_RELOAD;
          if (r_stop == STOP_LAST) begin
            if (!w_empty) begin
              w_pop       = 1'b1;
              w_shift_nxt = w_fifo_dout;
              w_state_nxt = ST_START;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_stop_nxt = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud - BAUD_W'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Line level implied by the current state.
  always_comb begin
    w_tx_bit = 1'b1;
    case (r_state)
      ST_IDLE:  w_tx_bit = 1'b1;
      ST_START: w_tx_bit = 1'b0;
      ST_DATA:  w_tx_bit = r_shift[0];
      ST_STOP:  w_tx_bit = 1'b1;
      default:  w_tx_bit = 1'b1;
    endcase
  end

  // Registered serial output; reset forces the line to idle immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_tx <= 1'b1;
    end else begin
      r_tx <= w_tx_bit;
    end
  end

endmodule

// File: tb/tb_servant_uart.sv
// Directed bench for servant_uart: 8N1 instance (dut) and 7-data/2-stop
// instance (dut2), both CLK_DIV=4, FIFO_DEPTH=4.
`timescale 1ns/1ps
module tb_servant_uart;
  import servant_uart_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        bus_sel;
  logic        stb;
  logic        we;
  logic        adr;
  logic [31:0] dat;
  logic        stb0, stb1;
  logic [31:0] rdt0, rdt1, rdt_m;
  logic        ack0, ack1, ack_m;
  logic        tx0, tx1, irq0, irq1;

  always #5 clk = ~clk;

  assign stb0  = stb & ~bus_sel;
  assign stb1  = stb &  bus_sel;
  assign ack_m = bus_sel ? ack1 : ack0;
  assign rdt_m = bus_sel ? rdt1 : rdt0;

  servant_uart #(.CLK_DIV(4), .FIFO_DEPTH(4), .DATA_W(8), .STOP_BITS(1)) dut (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_we(we),
    .i_wb_stb(stb0), .o_wb_rdt(rdt0), .o_wb_ack(ack0), .o_uart_tx(tx0), .o_irq(irq0));

  servant_uart #(.CLK_DIV(4), .FIFO_DEPTH(4), .DATA_W(7), .STOP_BITS(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_we(we),
    .i_wb_stb(stb1), .o_wb_rdt(rdt1), .o_wb_ack(ack1), .o_uart_tx(tx1), .o_irq(irq1));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]  rx_q[$];
  int          rx_start_q[$];
  logic [39:0] rx_raw = 40'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Serial receiver for dut: one sample per cycle over a 40-cycle frame.
  initial begin : rx_mon
    logic [39:0] raw;
    logic [7:0]  b;
    bit          abort;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && tx0 === 1'b0) begin
        raw    = 40'd0;
        abort  = 1'b0;
        raw[0] = tx0;
        rx_start_q.push_back(cyc);
        for (int i = 1; i < 40; i++) begin
          @(negedge clk);
          if (rst !== 1'b0) abort = 1'b1;
          raw[i] = tx0;
        end
        if (!abort) begin
          for (int k = 0; k < 8; k++) b[k] = raw[4*(k+1)+2];
          rx_raw = raw;
          rx_q.push_back(b);
        end
      end
    end
  end

  task automatic bus_xfer(input logic sel, input logic a, input logic w,
                          input logic [31:0] d, output logic [31:0] r);
    int budget;
    @(negedge clk);
    bus_sel = sel; adr = a; we = w; dat = d; stb = 1'b1;
    budget = 0;
    do begin
      @(posedge clk); #1;
      budget++;
    end while (ack_m !== 1'b1 && budget < 8);
    if (ack_m !== 1'b1) check_eq("ack_timeout", {63'd0, ack_m}, 64'd1);
    r   = rdt_m;
    stb = 1'b0;
    we  = 1'b0;
  endtask

  task automatic wr(input logic sel, input logic a, input logic [31:0] d);
    logic [31:0] r;
    bus_xfer(sel, a, 1'b1, d, r);
  endtask

  task automatic rd(input logic sel, input logic a, output logic [31:0] r);
    bus_xfer(sel, a, 1'b0, 32'd0, r);
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      @(posedge clk);
      k++;
    end
    check_eq(tag, rx_q.size(), n);
  endtask

  task automatic rx_pop(output logic [8:0] v);
    if (rx_q.size() > 0) v = {1'b0, rx_q.pop_front()};
    else v = 9'h1FF;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [31:0] r;
    logic [8:0]  v;
    logic [79:0] raw2;
    int          d;
    rst = 1'b1; stb = 1'b0; we = 1'b0; adr = 1'b0; dat = 32'd0; bus_sel = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx",  tx0,  1);
    check_eq("rst_ack", ack0, 0);
    check_eq("rst_rdt", rdt0, 0);
    check_eq("rst_irq", irq0, 0);
    check_eq("rst_tx2", tx1,  1);
    @(negedge clk);
    rst = 1'b0;
    rd(1'b0, ADDR_CTRL, r);
    check_eq("rst_status", r, 32'h0000_0002);
    rd(1'b0, ADDR_DATA, r);
    check_eq("data_read_zero", r, 32'h0);

    // Scenario 1: 0x55, fall two edges after ack, exact 40-cycle waveform
    rx_q.delete(); rx_start_q.delete();
    wr(1'b0, ADDR_DATA, 32'h55);
    @(posedge clk); #1;
    check_eq("s1_tx_edge1", tx0, 1);
    check_eq("s1_ack_pulse", ack0, 0);
    @(posedge clk); #1;
    check_eq("s1_tx_edge2", tx0, 0);
    wait_rx(1, 60, "s1_rx_count");
    rx_pop(v);
    check_eq("s1_byte", v, 9'h055);
    check_eq("s1_raw", rx_raw, 40'hF0_F0F0_F0F0);

    // Scenario 2: back-to-back frames, no idle gap
    rx_q.delete(); rx_start_q.delete();
    wr(1'b0, ADDR_DATA, 32'hA1);
    wr(1'b0, ADDR_DATA, 32'h0F);
    rd(1'b0, ADDR_CTRL, r);
    check_eq("s2_status_cnt1", r, 32'h0000_0104);
    wait_rx(1, 60, "s2_rx_first");
    rd(1'b0, ADDR_CTRL, r);
    check_eq("s2_status_cnt0", r, 32'h0000_0006);
    wait_rx(2, 60, "s2_rx_count");
    d = (rx_start_q.size() >= 2) ? (rx_start_q[1] - rx_start_q[0]) : -1;
    check_eq("s2_gap", d, 40);
    rx_pop(v);
    check_eq("s2_byte0", v, 9'h0A1);
    rx_pop(v);
    check_eq("s2_byte1", v, 9'h00F);
    rd(1'b0, ADDR_CTRL, r);
    check_eq("s2_status_idle", r, 32'h0000_0002);

    // Scenario 3: six writes, one dropped; overflow sticky until read
    rx_q.delete(); rx_start_q.delete();
    for (int i = 0; i < 6; i++) wr(1'b0, ADDR_DATA, 32'h11 + i);
    rd(1'b0, ADDR_CTRL, r);
    check_eq("s3_status_ovf", r, 32'h0000_040D);  // full|busy|overflow, count 4
    rd(1'b0, ADDR_CTRL, r);
    check_eq("s3_status_clr", r, 32'h0000_0405);
    wait_rx(5, 260, "s3_rx_count");
    for (int i = 0; i < 5; i++) begin
      rx_pop(v);
      check_eq("s3_byte", v, 9'h011 + 9'(i));
    end
    repeat (60) @(posedge clk);
    check_eq("s3_no_extra", rx_q.size(), 0);
    rd(1'b0, ADDR_CTRL, r);
    check_eq("s3_status_end", r, 32'h0000_0002);

    // Scenario 4: transmit-complete interrupt
    rx_q.delete(); rx_start_q.delete();
    wr(1'b0, ADDR_CTRL, 32'h1);
    @(posedge clk); #1;
    check_eq("s4_irq_idle", irq0, 1);
    wr(1'b0, ADDR_DATA, 32'h00);
    repeat (20) @(posedge clk);
    #1;
    check_eq("s4_irq_mid", irq0, 0);
    repeat (21) @(posedge clk);
    #1;
    check_eq("s4_irq_last_stop", irq0, 0);
    @(posedge clk); #1;
    check_eq("s4_irq_done", irq0, 1);
    wait_rx(1, 10, "s4_rx_count");
    rx_pop(v);
    check_eq("s4_byte", v, 9'h000);
    wr(1'b0, ADDR_CTRL, 32'hFFFF_FFFE);
    @(posedge clk); #1;
    check_eq("s4_irq_off", irq0, 0);
    rd(1'b0, ADDR_CTRL, r);
    check_eq("s4_status", r, 32'h0000_0002);

    // Scenario 5: reset during data bit 3 with two bytes queued
    rx_q.delete(); rx_start_q.delete();
    wr(1'b0, ADDR_DATA, 32'h81);
    wr(1'b0, ADDR_DATA, 32'h82);
    wr(1'b0, ADDR_DATA, 32'h83);
    repeat (16) @(posedge clk);
    #1;
    check_eq("s5_bit3_low", tx0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("s5_async_tx", tx0, 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    rd(1'b0, ADDR_CTRL, r);
    check_eq("s5_status", r, 32'h0000_0002);
    repeat (100) @(posedge clk);
    #1;
    check_eq("s5_no_frames", rx_q.size(), 0);
    check_eq("s5_tx_idle", tx0, 1);

    // Scenario 6: 7 data bits, 2 stop bits, two frames back to back
    wr(1'b1, ADDR_DATA, 32'h7F);
    wr(1'b1, ADDR_DATA, 32'h00);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      raw2[i] = tx1;
    end
    check_eq("s6_frame0", raw2[39:0],  40'hFF_FFFF_FFF0);
    check_eq("s6_frame1", raw2[79:40], 40'hFF_0000_0000);
    rd(1'b1, ADDR_CTRL, r);
    check_eq("s6_status", r, 32'h0000_0002);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
